// File: rtl/bg_mask_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : bg_mask_engine_if
// Description : Pixel-stream bundle for bg_mask_engine. Carries the incoming
//               column stream (frame start, column valid, 3-pixel RGB
//               column, background gray) and the outgoing mask stream
//               (valid, smoothed gray, foreground mask).
//               master : stream producer / mask consumer side (testbench,
//                        line-buffer wrapper)
//               slave  : the engine itself
// Revision    : 1.0 - initial release
// ============================================================================
interface bg_mask_engine_if #(
    parameter int PIX_W = 8
);
    logic                 i_frame_start;  // one-cycle pulse at VS negedge
    logic                 i_valid;        // column valid
    logic [9*PIX_W-1:0]   i_col;          // 3 RGB pixels, top line in LSBs
    logic [PIX_W-1:0]     i_back_gray;    // background gray of output pixel
    logic                 o_valid;        // o_gray / o_mask valid
    logic [PIX_W-1:0]     o_gray;         // smoothed gray
    logic                 o_mask;         // foreground mask

    modport master (
        output i_frame_start, i_valid, i_col, i_back_gray,
        input  o_valid, o_gray, o_mask
    );

    modport slave (
        input  i_frame_start, i_valid, i_col, i_back_gray,
        output o_valid, o_gray, o_mask
    );
endinterface
`default_nettype wire

// File: rtl/bg_mask_engine.sv
`default_nettype none
// ============================================================================
// Module      : bg_mask_engine
// Description : Background-subtraction engine. Converts each 3-pixel RGB
//               column to gray, smooths with a 3x3 window made of four 2x2
//               means, compares against the background gray and emits a
//               1-bit foreground mask. The threshold is learned once per
//               frame from the mean absolute error of the previous full
//               frame plus a runtime offset.
// Ports       : clk            clock
//               rst_n          synchronous active-low reset
//               bus (slave)    column stream in / mask stream out
//               i_thr_offset   threshold offset added to the learned base
//               o_threshold    registered threshold (base + offset)
//               o_short_frame  pulse: previous frame was incomplete
// Options     : BGM_HYST_EN    when defined, a pixel that was foreground
//                              stays foreground down to threshold - HYST
// Revision    : 1.0 - initial release
// ============================================================================
module bg_mask_engine #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int PIX_W  = 8,
    parameter int ACC_W  = 32,
    parameter int RECIP  = 4489,
    parameter int SHIFT  = 31,
    parameter int HYST   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bg_mask_engine_if.slave   bus,
    input  logic [PIX_W-1:0]  i_thr_offset,
    output logic [ACC_W-1:0]  o_threshold,
    output logic              o_short_frame
);

    localparam int PIX_PER_FRAME = WIDTH * (HEIGHT - 2);
    localparam int CNT_W         = $clog2(PIX_PER_FRAME + 1);
    localparam int GW            = PIX_W + 7;   // weights sum to 128
    localparam int PW            = ACC_W + 16;  // reciprocal product width
    localparam logic [CNT_W-1:0] PPF_C = CNT_W'(PIX_PER_FRAME);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [PIX_W-1:0] to_gray(input logic [3*PIX_W-1:0] px);
        logic [GW-1:0] s;
        s = GW'(px[2*PIX_W +: PIX_W]) * GW'(38)
          + GW'(px[PIX_W   +: PIX_W]) * GW'(75)
          + GW'(px[0       +: PIX_W]) * GW'(15);
        return PIX_W'(s >> 7);
    endfunction

    function automatic logic [PIX_W+1:0] mean4(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b,
                                               input logic [PIX_W-1:0] c,
                                               input logic [PIX_W-1:0] d);
        logic [PIX_W+1:0] s;
        s = (PIX_W+2)'(a) + (PIX_W+2)'(b) + (PIX_W+2)'(c) + (PIX_W+2)'(d);
        return s >> 2;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                prime_q, prime_d;   // one priming column seen
    logic [PIX_W-1:0]    c1_q [3];
    logic [PIX_W-1:0]    c2_q [3];
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PIX_W-1:0]    base_q;
    logic [ACC_W-1:0]    thr_q;
    logic                valid_q;
    logic [PIX_W-1:0]    gray_q;
    logic                mask_q;
    logic                short_q;

    logic [PIX_W-1:0]    w_c0 [3];
    logic [PIX_W+1:0]    w_m1, w_m2, w_m3, w_m4, w_total;
    logic [PIX_W-1:0]    w_gray;
    logic [PIX_W-1:0]    w_err;
    logic [ACC_W-1:0]    w_thr_eff;
    logic                w_mask;
    logic                w_run_col;          // column produces an output
    logic                w_shift;            // column enters the window
    logic [PW-1:0]       w_prod;
    logic [PW-1:0]       w_scaled;
    logic [PIX_W-1:0]    w_base_new;

    // ------------------------------------------------------------------
    // Gray conversion of the incoming column
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 3; k++) begin : g_gray
        assign w_c0[k] = to_gray(bus.i_col[k*3*PIX_W +: 3*PIX_W]);
    end

    // ------------------------------------------------------------------
    // 3x3 smoothing as the mean of four overlapping 2x2 means
    // ------------------------------------------------------------------
    assign w_m1    = mean4(w_c0[0], w_c0[1], c1_q[0], c1_q[1]);
    assign w_m2    = mean4(w_c0[1], w_c0[2], c1_q[1], c1_q[2]);
    assign w_m3    = mean4(c1_q[0], c1_q[1], c2_q[0], c2_q[1]);
    assign w_m4    = mean4(c1_q[1], c1_q[2], c2_q[1], c2_q[2]);
    assign w_total = w_m1 + w_m2 + w_m3 + w_m4;
    assign w_gray  = PIX_W'(w_total >> 2);

    assign w_err = (w_gray >= bus.i_back_gray) ? (w_gray - bus.i_back_gray)
                                               : (bus.i_back_gray - w_gray);

    // ------------------------------------------------------------------
    // Threshold (optionally relaxed for pixels that were foreground)
    // ------------------------------------------------------------------
`ifdef BGM_HYST_EN
    logic prev_mask_q;

    always_comb begin
        w_thr_eff = thr_q;
        if (prev_mask_q) begin
            w_thr_eff = (thr_q > ACC_W'(HYST)) ? (thr_q - ACC_W'(HYST)) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_mask_q <= 1'b0;
        end else if (bus.i_frame_start) begin
            prev_mask_q <= 1'b0;
        end else if (w_run_col) begin
            prev_mask_q <= w_mask;
        end
    end
`else
    assign w_thr_eff = thr_q;
`endif

    assign w_mask = (ACC_W'(w_err) >= w_thr_eff);

    // Mean absolute error of the frame: acc * (1/N), clamped to a gray value
    assign w_prod     = PW'(acc_q) * PW'(RECIP);
    assign w_scaled   = w_prod >> SHIFT;
    assign w_base_new = (w_scaled > PW'({PIX_W{1'b1}})) ? {PIX_W{1'b1}}
                                                        : PIX_W'(w_scaled);

    // ------------------------------------------------------------------
    // Frame state machine: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        prime_d   = prime_q;
        w_run_col = 1'b0;
        w_shift   = 1'b0;
        if (bus.i_frame_start) begin
            // A coincident column is the first priming column of the frame
            state_d = S_PRIME;
            prime_d = bus.i_valid;
        end else begin
            case (state_q)
                S_PRIME: begin
                    w_shift = bus.i_valid;
                    if (bus.i_valid) begin
                        if (prime_q) begin
                            state_d = S_RUN;
                            prime_d = 1'b0;
                        end else begin
                            prime_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    w_shift   = bus.i_valid;
                    w_run_col = bus.i_valid;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prime_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                c1_q[k] <= '0;
                c2_q[k] <= '0;
            end
            acc_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            thr_q   <= '0;
            valid_q <= 1'b0;
            gray_q  <= '0;
            mask_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prime_q <= prime_d;
            // base is sampled before its own update, so a new base shows
            // up on o_threshold one cycle after the frame start
            thr_q   <= ACC_W'(base_q) + ACC_W'(i_thr_offset);
            valid_q <= w_run_col;
            short_q <= 1'b0;

            if (bus.i_frame_start) begin
                for (int k = 0; k < 3; k++) begin
                    c1_q[k] <= bus.i_valid ? w_c0[k] : '0;
                    c2_q[k] <= '0;
                end
                acc_q <= '0;
                cnt_q <= '0;
                if (cnt_q == PPF_C) begin
                    base_q <= w_base_new;
                end else if (state_q != S_IDLE) begin
                    short_q <= 1'b1;
                end
            end else if (w_shift) begin
                for (int k = 0; k < 3; k++) begin
                    c1_q[k] <= w_c0[k];
                    c2_q[k] <= c1_q[k];
                end
            end

            if (w_run_col) begin
                gray_q <= w_gray;
                mask_q <= w_mask;
                if (cnt_q < PPF_C) begin
                    acc_q <= acc_q + ACC_W'(w_err);
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_gray     = gray_q;
    assign bus.o_mask     = mask_q;
    assign o_threshold    = thr_q;
    assign o_short_frame  = short_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_mask_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_bg_mask_engine
// Description : Self-checking bench for bg_mask_engine (small 4x4 frame,
//               RECIP=1, SHIFT=3 so the learned base is acc/8). Hand tables
//               and sequences plus randomized frames checked against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_mask_engine;

    localparam int PIX_W  = 8;
    localparam int ACC_W  = 32;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 4;
    localparam int RECIP  = 1;
    localparam int SHIFT  = 3;
    localparam int HYST   = 4;
    localparam int PPF    = WIDTH * (HEIGHT - 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PIX_W-1:0]  thr_off = '0;
    logic [ACC_W-1:0]  threshold;
    logic              short_frame;

    bg_mask_engine_if #(.PIX_W(PIX_W)) bus ();

    bg_mask_engine #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .PIX_W (PIX_W),
        .ACC_W (ACC_W),
        .RECIP (RECIP),
        .SHIFT (SHIFT),
        .HYST  (HYST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .i_thr_offset (thr_off),
        .o_threshold  (threshold),
        .o_short_frame(short_frame)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: keeps the gray columns of the current frame and
    // frame-level statistics; produces the expected outputs of each cycle.
    // ------------------------------------------------------------------
    typedef struct { int g0; int g1; int g2; } gcol_t;

    gcol_t  m_cols[$];
    bit     m_active;
    longint m_acc;
    int     m_cnt;
    int     m_base;
    longint m_thr;
    bit     m_prev;
    bit     m_exp_valid;
    int     m_exp_gray;
    bit     m_exp_mask;
    bit     m_exp_short;

    function automatic int pix_gray(input logic [71:0] col, input int k);
        int r, g, b;
        b = int'(col[k*24      +: 8]);
        g = int'(col[k*24 + 8  +: 8]);
        r = int'(col[k*24 + 16 +: 8]);
        return (r*38 + g*75 + b*15) / 128;
    endfunction

    function automatic gcol_t to_gcol(input logic [71:0] col);
        gcol_t c;
        c.g0 = pix_gray(col, 0);
        c.g1 = pix_gray(col, 1);
        c.g2 = pix_gray(col, 2);
        return c;
    endfunction

    task automatic model_reset();
        m_cols.delete();
        m_active = 0; m_acc = 0; m_cnt = 0; m_base = 0; m_thr = 0; m_prev = 0;
        m_exp_valid = 0; m_exp_gray = 0; m_exp_mask = 0; m_exp_short = 0;
    endtask

    task automatic model_step(input bit fs, input bit v, input logic [71:0] col,
                              input int back, input int off);
        longint thr_old = m_thr;
        int     base_old = m_base;
        m_exp_valid = 0;
        m_exp_short = 0;
        if (fs) begin
            if (m_cnt == PPF) begin
                longint q = (m_acc * RECIP) >> SHIFT;
                m_base = (q > 255) ? 255 : int'(q);
            end else if (m_active) begin
                m_exp_short = 1;
            end
            m_acc = 0; m_cnt = 0; m_active = 1; m_prev = 0;
            m_cols.delete();
            if (v) m_cols.push_back(to_gcol(col));
        end else if (m_active && v) begin
            m_cols.push_back(to_gcol(col));
            if (m_cols.size() > 3) void'(m_cols.pop_front());
            if (m_cols.size() == 3) begin
                gcol_t c0, c1, c2;
                int m1, m2, m3, m4, g, err;
                longint te;
                c0 = m_cols[2]; c1 = m_cols[1]; c2 = m_cols[0];
                m1 = (c0.g0 + c0.g1 + c1.g0 + c1.g1) / 4;
                m2 = (c0.g1 + c0.g2 + c1.g1 + c1.g2) / 4;
                m3 = (c1.g0 + c1.g1 + c2.g0 + c2.g1) / 4;
                m4 = (c1.g1 + c1.g2 + c2.g1 + c2.g2) / 4;
                g  = (m1 + m2 + m3 + m4) / 4;
                err = (g > back) ? g - back : back - g;
                te = thr_old;
`ifdef BGM_HYST_EN
                if (m_prev) te = (thr_old > HYST) ? thr_old - HYST : 0;
`endif
                m_exp_valid = 1;
                m_exp_gray  = g;
                m_exp_mask  = (err >= te);
                m_prev      = m_exp_mask;
                if (m_cnt < PPF) begin
                    m_acc += err;
                    m_cnt++;
                end
            end
        end
        m_thr = base_old + off;
    endtask

    // One clock cycle: drive, clock, advance model, compare against model
    task automatic cyc(input bit rv, input bit fs, input bit v,
                       input logic [71:0] col, input int back, input int off);
        rst_n             = rv;
        bus.i_frame_start = fs;
        bus.i_valid       = v;
        bus.i_col         = col;
        bus.i_back_gray   = PIX_W'(back);
        thr_off           = PIX_W'(off);
        @(posedge clk);
        if (!rv) model_reset();
        else     model_step(fs, v, col, back, off);
        #1;
        chk("model_valid", longint'(bus.o_valid), longint'(m_exp_valid));
        if (m_exp_valid) begin
            chk("model_gray", longint'(bus.o_gray), longint'(m_exp_gray));
            chk("model_mask", longint'(bus.o_mask), longint'(m_exp_mask));
        end
        chk("model_short", longint'(short_frame), longint'(m_exp_short));
        chk("model_thr", longint'(threshold), m_thr);
    endtask

    function automatic logic [71:0] mkcol(input int a, input int b, input int c);
        logic [71:0] x;
        x[23:0]  = {a[7:0], a[7:0], a[7:0]};
        x[47:24] = {b[7:0], b[7:0], b[7:0]};
        x[71:48] = {c[7:0], c[7:0], c[7:0]};
        return x;
    endfunction

    function automatic logic [71:0] rndcol();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[71:0];
    endfunction

    typedef struct {
        bit v; int p0; int p1; int p2; int back;
        bit ev; int eg; bit em;
    } vec_t;

    vec_t tbl[7];
    int   hyst_exp[3];

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [71:0] c80;
        c80 = mkcol(128, 128, 128);

        // channel value v on all of R,G,B gives gray == v
        tbl[0] = '{1, 128, 128, 128, 100, 0,   0, 0};
        tbl[1] = '{1, 128, 128, 128, 100, 0,   0, 0};
        tbl[2] = '{1, 128, 128, 128, 100, 1, 128, 1};
        tbl[3] = '{1,   0,   0,   0, 100, 1,  96, 0};
        tbl[4] = '{0,   7,   7,   7,   0, 0,   0, 0};
        tbl[5] = '{1, 255, 255, 255,   0, 1,  95, 1};
        tbl[6] = '{1,  10,  20,  30,  50, 1, 132, 1};

`ifdef BGM_HYST_EN
        hyst_exp[0] = 1; hyst_exp[1] = 1; hyst_exp[2] = 0;
`else
        hyst_exp[0] = 1; hyst_exp[1] = 0; hyst_exp[2] = 0;
`endif

        // ---- reset with random inputs ----
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'($urandom), 1'($urandom), rndcol(), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
        end
        chk("rst_valid", longint'(bus.o_valid), 0);
        chk("rst_gray",  longint'(bus.o_gray), 0);
        chk("rst_mask",  longint'(bus.o_mask), 0);
        chk("rst_thr",   longint'(threshold), 0);
        chk("rst_short", longint'(short_frame), 0);

        // columns before any frame start are ignored
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, c80, 100, 24);
            chk("idle_novalid", longint'(bus.o_valid), 0);
        end
        chk("idle_thr", longint'(threshold), 24);

        // ---- table-driven window / mask vectors ----
        cyc(1, 1, 0, c80, 100, 24);
        chk("first_fs_short", longint'(short_frame), 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, tbl[i].v, mkcol(tbl[i].p0, tbl[i].p1, tbl[i].p2), tbl[i].back, 24);
            chk($sformatf("tbl%0d_valid", i), longint'(bus.o_valid), longint'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_gray", i), longint'(bus.o_gray), tbl[i].eg);
                chk($sformatf("tbl%0d_mask", i), longint'(bus.o_mask), longint'(tbl[i].em));
            end
        end

        // ---- threshold learning: 8 pixels at err 28 ----
        cyc(1, 1, 0, c80, 100, 24);
        chk("tbl_frame_short", longint'(short_frame), 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, c80, 100, 24);
        chk("learn_gray", longint'(bus.o_gray), 128);
        chk("learn_mask_before", longint'(bus.o_mask), 1);
        cyc(1, 1, 0, c80, 100, 24);
        chk("learn_noshort", longint'(short_frame), 0);
        chk("learn_thr_old", longint'(threshold), 24);
        cyc(1, 0, 0, c80, 100, 24);
        chk("learn_thr_new", longint'(threshold), 52);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, c80, 100, 24);
        chk("learn_valid", longint'(bus.o_valid), 1);
        chk("learn_mask_after", longint'(bus.o_mask), 0);

        // ---- short frame: 5 pixels then frame start ----
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, c80, 100, 24);
        cyc(1, 1, 0, c80, 100, 24);
        chk("short_pulse", longint'(short_frame), 1);
        cyc(1, 0, 0, c80, 100, 24);
        chk("short_clear", longint'(short_frame), 0);
        chk("short_thr_kept", longint'(threshold), 52);

        // ---- frame start coincident with a valid column ----
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, c80, 100, 24);
        cyc(1, 1, 1, c80, 100, 24);
        chk("coin_v0", longint'(bus.o_valid), 0);
        cyc(1, 0, 1, c80, 100, 24);
        chk("coin_v1", longint'(bus.o_valid), 0);
        cyc(1, 0, 1, c80, 100, 24);
        chk("coin_v2", longint'(bus.o_valid), 1);

        // ---- reset mid-frame ----
        cyc(0, 1'($urandom), 1, rndcol(), int'($urandom_range(0, 255)), 24);
        chk("mid_rst_valid", longint'(bus.o_valid), 0);
        chk("mid_rst_thr",   longint'(threshold), 0);
        chk("mid_rst_gray",  longint'(bus.o_gray), 0);
        cyc(1, 0, 1, c80, 100, 24);
        chk("post_rst_valid", longint'(bus.o_valid), 0);
        chk("post_rst_thr", longint'(threshold), 24);
        cyc(1, 1, 0, c80, 100, 24);
        chk("post_rst_noshort", longint'(short_frame), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, c80, 100, 24);
            chk($sformatf("post_rst_col%0d", i), longint'(bus.o_valid), (i == 2) ? 1 : 0);
        end

        // ---- hysteresis: threshold 52, err 60, 50, 47 ----
        cyc(1, 1, 0, c80, 68, 52);
        cyc(1, 0, 1, c80, 68, 52);
        cyc(1, 0, 1, c80, 68, 52);
        cyc(1, 0, 1, c80, 68, 52);
        chk("hyst_err60", longint'(bus.o_mask), hyst_exp[0]);
        cyc(1, 0, 1, c80, 78, 52);
        chk("hyst_err50", longint'(bus.o_mask), hyst_exp[1]);
        cyc(1, 0, 1, c80, 81, 52);
        chk("hyst_err47", longint'(bus.o_mask), hyst_exp[2]);

        // ---- randomized frames against the model ----
        for (int f = 0; f < 12; f++) begin
            int n;
            cyc(1, 1, 1'($urandom), rndcol(), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 80)));
            n = int'($urandom_range(3, 16));
            for (int i = 0; i < n; i++) begin
                cyc(1, 0, ($urandom % 4) != 0, rndcol(), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 80)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
